icmp_echo_responder: RTL and testbench
======================================

Name: icmp_echo_responder

Overview:
- Parametrised store-and-forward ICMP echo responder on 32-bit Avalon-ST, sitting between TUN/TAP ingress and egress streams.
- Buffers one raw IPv4 packet (no Ethernet header) and validates it. An echo request gets src/dst IP swapped, type set to 0 and its checksum updated incrementally with end-around carry.
- Non-echo traffic is forwarded unmodified or dropped, selected by parameter. Full backpressure on both sides; buffer is single-port-RAM friendly.

Parameters:
- DEPTH, 64, buffer depth in 32-bit words (power of two, >= 8); maximum accepted packet length.
- PASS_OTHER, 1, 1 = forward non-echo packets unchanged; 0 = drop them.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- stream_in_data  in  32  packet word; wire byte 0 in bits [7:0]
- stream_in_empty  in  2  empty bytes on the EOP beat
- stream_in_valid  in  1  input beat valid
- stream_in_startofpacket  in  1  first beat
- stream_in_endofpacket  in  1  last beat
- stream_in_ready  out  1  block accepts a beat
- stream_out_data  out  32  output word
- stream_out_empty  out  2  empty bytes, valid on the EOP beat
- stream_out_valid  out  1  output beat valid
- stream_out_startofpacket  out  1  first output beat
- stream_out_endofpacket  out  1  last output beat
- stream_out_ready  in  1  sink accepts a beat (readyLatency 0)

Behaviour:
- Reset: state IDLE; stream_in_ready, stream_out_valid, stream_out_startofpacket and stream_out_endofpacket are 0; stream_out_data and stream_out_empty are 0; pointers are 0. Buffer contents don't care. Reset mid-packet abandons the packet with no partial output.
- An input beat transfers when valid && ready. An output beat transfers when valid && stream_out_ready. While stalled, all stream_out_* outputs hold stable.
- IDLE: stream_in_ready = 1. A non-SOP beat is discarded. A SOP beat is written to word 0 and the block goes to RECV.
- RECV: each beat is written at wr_ptr, which then increments.
  - SOP beat in RECV: restart the packet at word 0; the previous packet is lost.
  - EOP beat: latch len = wr_ptr+1 and empty; drop stream_in_ready the next cycle; go to CHECK.
  - Beat DEPTH+1 (overflow): go to DROP.
- DROP: ready = 1; discard beats through EOP; return to IDLE. Nothing is output.
- CHECK (1 cycle): the packet is an echo request iff all of the following hold:
  - len >= 6
  - word0[7:4] == 4 and word0[3:0] == 5
  - word2[15:8] == 1
  - word5[7:0] == 8
- CHECK outcome:
  - Echo request: go to SEND with the modify flag set.
  - Non-echo with PASS_OTHER = 1: go to SEND with the flag clear.
  - Non-echo with PASS_OTHER = 0: go to IDLE.
- SEND reads the buffer sequentially (1-cycle read latency, prefetch allowed). When the modify flag is set, these substitutions apply on the fly:
  - word3 outputs buffer word4; word4 outputs buffer word3.
  - word5[7:0] outputs 0.
  - Let c = {word5[23:16], word5[31:24]} (big-endian checksum). Compute s = c + 0x0800 in 17 bits; c' = s[15:0] + s[16]. word5[31:16] outputs {c'[7:0], c'[15:8]}. Example: c = 0xF7FF gives c' = 0xFFFF; c = 0xF800 gives c' = 0x0001.
- SEND framing:
  - startofpacket = 1 on word 0 only; endofpacket = 1 on word len-1 only.
  - stream_out_empty = latched empty on the EOP beat, 0 otherwise.
  - After the EOP transfer: valid = 0; return to IDLE; ready = 1 on the following cycle.
- Latency: first output beat no earlier than 3 cycles after the EOP input transfer. Throughput in SEND is 1 word/cycle when stream_out_ready = 1.
- Single-beat packet (SOP && EOP): len = 1, non-echo.

Optional Feature:
- Macro: ICMP_ECHO_STATS_EN.
- Defined: adds outputs stat_echo_cnt, stat_pass_cnt, stat_drop_cnt, stat_ovf_cnt (each 16-bit, saturating) and input stat_clear (1-bit, synchronous, zeroes all four).
  - stat_echo_cnt increments on the EOP transfer of a modified packet.
  - stat_pass_cnt increments on the EOP transfer of a forwarded packet.
  - stat_drop_cnt increments in CHECK for a non-echo packet when PASS_OTHER = 0, and on each SOP restart in RECV.
  - stat_ovf_cnt increments on entry to DROP.
  - All four reset to 0.
- Undefined: ports and logic are absent; data-path behaviour is identical.

Test Plan:
- 84-byte echo request (21 words, empty = 0), checksum field 0xF7FF, sink always ready → 21 words out; words 3/4 swapped; type 0; checksum 0xFFFF; SOP on beat 0, EOP on beat 20.
- Same packet with checksum 0xF800, stream_out_ready toggling 1-0-1 → checksum 0x0001; data stable while stalled; no beat lost or duplicated.
- UDP packet (protocol 17), 10 words, empty = 2 → with PASS_OTHER = 1, byte-identical output with empty = 2 on EOP; with PASS_OTHER = 0, no output and drop counter = 1.
- DEPTH = 16, 20-word packet followed by a valid 8-word echo → first packet produces no output and ovf = 1; second is replied correctly.
- SOP at beat 4 of a packet in progress, followed by a full echo → only the second packet is output; drop counter = 1.
- Reset asserted for 1 cycle during SEND word 7 → next cycle valid = 0; a following echo is handled normally.

Source files
------------

// File: rtl/icmp_echo_responder.sv
// -----------------------------------------------------------------------------
// icmp_echo_responder
//
// Store-and-forward ICMP echo responder on 32-bit Avalon-ST streams. One raw
// IPv4 packet (no Ethernet header) is buffered, classified, and replayed.
// Echo requests come back as echo replies:
//   - source and destination IP words are swapped
//   - the ICMP type byte is set to 0
//   - the ICMP checksum is patched incrementally
// Other traffic is forwarded unchanged (PASS_OTHER = 1) or dropped
// (PASS_OTHER = 0).
//
// Parameters:
//   DEPTH       buffer depth in 32-bit words (power of two, >= 8)
//   PASS_OTHER  1 = forward non-echo packets, 0 = drop them
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   stream_in_*                Avalon-ST sink (data/empty/valid/sop/eop/ready)
//   stream_out_*               Avalon-ST source, readyLatency 0
//   stat_* (optional)          saturating 16-bit event counters + clear
//
// Optional feature macro: ICMP_ECHO_STATS_EN (adds the stat_* ports/logic).
//
// Byte order: wire byte 0 of each word sits in bits [7:0].
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module icmp_echo_responder #(
    parameter int DEPTH      = 64,
    parameter int PASS_OTHER = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] stream_in_data,
    input  logic [1:0]  stream_in_empty,
    input  logic        stream_in_valid,
    input  logic        stream_in_startofpacket,
    input  logic        stream_in_endofpacket,
    output logic        stream_in_ready,
    output logic [31:0] stream_out_data,
    output logic [1:0]  stream_out_empty,
    output logic        stream_out_valid,
    output logic        stream_out_startofpacket,
    output logic        stream_out_endofpacket,
    input  logic        stream_out_ready
`ifdef ICMP_ECHO_STATS_EN
    ,
    input  logic        stat_clear,
    output logic [15:0] stat_echo_cnt,
    output logic [15:0] stat_pass_cnt,
    output logic [15:0] stat_drop_cnt,
    output logic [15:0] stat_ovf_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    // One extra bit so the write pointer can reach DEPTH and flag overflow.
    localparam int PW = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RECV  = 3'd1,
        S_DROP  = 3'd2,
        S_CHECK = 3'd3,
        S_SEND  = 3'd4
    } state_t;

    // -------------------------------------------------------------------------
    // Helpers
    // -------------------------------------------------------------------------

    // Incremental checksum patch for type 8 -> 0: add 0x0800 with end-around carry.
    function automatic logic [15:0] csum_patch(input logic [15:0] c);
        logic [16:0] s;
        s = {1'b0, c} + 17'h00800;
        return s[15:0] + {15'h0000, s[16]};
    endfunction

    // Read address map: words 3 and 4 (IP addresses) swap places on a reply.
    function automatic logic [AW-1:0] rd_map(input logic [PW-1:0] idx, input logic modify);
        logic [AW-1:0] a;
        if (modify && (idx == PW'(3))) begin
            a = AW'(4);
        end else if (modify && (idx == PW'(4))) begin
            a = AW'(3);
        end else begin
            a = idx[AW-1:0];
        end
        return a;
    endfunction

    // -------------------------------------------------------------------------
    // Registers and wires
    // -------------------------------------------------------------------------
    state_t        r_state;
    state_t        w_next_state;

    logic          r_in_ready;
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_len;
    logic [1:0]    r_empty;

    // Header fields snooped while the packet is written, so CHECK needs no reads.
    logic [7:0]    r_ver_ihl;
    logic [7:0]    r_proto;
    logic [7:0]    r_icmp_type;
    logic [15:0]   r_csum;
    logic [15:0]   r_csum_new;
    logic          r_modify;

    // Send side: read pointer, RAM output word and its index, output register.
    logic [PW-1:0] r_rd_ptr;
    logic          r_q_valid;
    logic [PW-1:0] r_q_idx;
    logic [31:0]   r_mem_q;
    logic [31:0]   r_mem [DEPTH];

    logic [31:0]   r_out_data;
    logic [1:0]    r_out_empty;
    logic          r_out_valid;
    logic          r_out_sop;
    logic          r_out_eop;

    logic          w_in_fire;
    logic          w_mem_we;
    logic [PW-1:0] w_wr_idx;
    logic          w_len_latch;
    logic          w_is_echo;
    logic          w_out_load;
    logic          w_out_fire;
    logic          w_done;
    logic          w_rd_en;
    logic [AW-1:0] w_mem_addr;
    logic [31:0]   w_out_word;

    assign w_in_fire  = stream_in_valid && r_in_ready;
    assign w_out_fire = r_out_valid && stream_out_ready;
    assign w_done     = w_out_fire && r_out_eop;
    // The RAM word moves to the output register whenever that register is free or draining.
    assign w_out_load = r_q_valid && (!r_out_valid || stream_out_ready);
    // Prefetch the next word when the RAM output slot will be empty after this cycle.
    assign w_rd_en    = (r_state == S_SEND) && (r_rd_ptr < r_len) && (!r_q_valid || w_out_load);
    assign w_is_echo  = (r_len >= PW'(6)) && (r_ver_ihl == 8'h45) &&
                        (r_proto == 8'h01) && (r_icmp_type == 8'h08);
    // Single shared address: writes only happen while receiving, reads only while sending.
    assign w_mem_addr = (r_state == S_SEND) ? rd_map(r_rd_ptr, r_modify) : w_wr_idx[AW-1:0];

    // Next-state logic and receive-side write control.
    always_comb begin
        w_next_state = r_state;
        w_mem_we     = 1'b0;
        w_wr_idx     = {PW{1'b0}};
        w_len_latch  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_in_fire && stream_in_startofpacket) begin
                    w_mem_we = 1'b1;
                    if (stream_in_endofpacket) begin
                        w_len_latch  = 1'b1;
                        w_next_state = S_CHECK;
                    end else begin
                        w_next_state = S_RECV;
                    end
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_RECV: begin
                if (w_in_fire) begin
                    if (stream_in_startofpacket) begin
                        // Restart: the previous partial packet is abandoned.
                        w_mem_we = 1'b1;
                        if (stream_in_endofpacket) begin
                            w_len_latch  = 1'b1;
                            w_next_state = S_CHECK;
                        end else begin
                            w_next_state = S_RECV;
                        end
                    end else if (r_wr_ptr == PW'(DEPTH)) begin
                        // Beat DEPTH+1 does not fit; an overflow beat that is
                        // itself EOP leaves nothing left to discard.
                        if (stream_in_endofpacket) begin
                            w_next_state = S_IDLE;
                        end else begin
                            w_next_state = S_DROP;
                        end
                    end else begin
                        w_mem_we = 1'b1;
                        w_wr_idx = r_wr_ptr;
                        if (stream_in_endofpacket) begin
                            w_len_latch  = 1'b1;
                            w_next_state = S_CHECK;
                        end else begin
                            w_next_state = S_RECV;
                        end
                    end
                end else begin
                    w_next_state = S_RECV;
                end
            end
            S_DROP: begin
                if (w_in_fire && stream_in_endofpacket) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_next_state = S_DROP;
                end
            end
            S_CHECK: begin
                if (w_is_echo || (PASS_OTHER != 0)) begin
                    w_next_state = S_SEND;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_SEND: begin
                if (w_done) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_next_state = S_SEND;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Reply substitutions applied to the word leaving the RAM.
    always_comb begin
        w_out_word = r_mem_q;
        if (r_modify && (r_q_idx == PW'(5))) begin
            w_out_word = {r_csum_new[7:0], r_csum_new[15:8], r_mem_q[15:8], 8'h00};
        end else begin
            w_out_word = r_mem_q;
        end
    end

    // State register and input-side ready (ready follows the next state).
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_in_ready <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_in_ready <= (w_next_state == S_IDLE) || (w_next_state == S_RECV) ||
                          (w_next_state == S_DROP);
        end
    end

    // Receive bookkeeping: write pointer, length/empty latch, header snooping, classify.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr    <= {PW{1'b0}};
            r_len       <= {PW{1'b0}};
            r_empty     <= 2'b00;
            r_ver_ihl   <= 8'h00;
            r_proto     <= 8'h00;
            r_icmp_type <= 8'h00;
            r_csum      <= 16'h0000;
            r_csum_new  <= 16'h0000;
            r_modify    <= 1'b0;
        end else begin
            if (w_mem_we) begin
                r_wr_ptr <= w_wr_idx + PW'(1);
                case (w_wr_idx)
                    PW'(0): r_ver_ihl <= stream_in_data[7:0];
                    PW'(2): r_proto   <= stream_in_data[15:8];
                    PW'(5): begin
                        r_icmp_type <= stream_in_data[7:0];
                        r_csum      <= {stream_in_data[23:16], stream_in_data[31:24]};
                    end
                    default: begin
                    end
                endcase
            end else if (r_state == S_CHECK) begin
                r_wr_ptr <= {PW{1'b0}};
            end
            if (w_len_latch) begin
                r_len   <= w_wr_idx + PW'(1);
                r_empty <= stream_in_empty;
            end
            if (r_state == S_CHECK) begin
                r_modify   <= w_is_echo;
                r_csum_new <= csum_patch(r_csum);
            end
        end
    end

    // Packet buffer: one write or one read per cycle, registered read data.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= stream_in_data;
        end
        if (w_rd_en) begin
            r_mem_q <= r_mem[w_mem_addr];
        end
    end

    // Send-side read pointer and RAM-output occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_ptr  <= {PW{1'b0}};
            r_q_valid <= 1'b0;
            r_q_idx   <= {PW{1'b0}};
        end else begin
            if (r_state == S_CHECK) begin
                r_rd_ptr <= {PW{1'b0}};
            end else if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (w_rd_en) begin
                r_q_valid <= 1'b1;
                r_q_idx   <= r_rd_ptr;
            end else if (w_out_load) begin
                r_q_valid <= 1'b0;
            end
        end
    end

    // Output register: changes only when empty or when the current beat transfers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_data  <= 32'h0000_0000;
            r_out_empty <= 2'b00;
            r_out_valid <= 1'b0;
            r_out_sop   <= 1'b0;
            r_out_eop   <= 1'b0;
        end else if (w_out_load) begin
            r_out_data  <= w_out_word;
            r_out_valid <= 1'b1;
            r_out_sop   <= (r_q_idx == {PW{1'b0}});
            r_out_eop   <= (r_q_idx == (r_len - PW'(1)));
            r_out_empty <= (r_q_idx == (r_len - PW'(1))) ? r_empty : 2'b00;
        end else if (w_out_fire) begin
            r_out_valid <= 1'b0;
            r_out_sop   <= 1'b0;
            r_out_eop   <= 1'b0;
            r_out_empty <= 2'b00;
        end
    end

    assign stream_in_ready          = r_in_ready;
    assign stream_out_data          = r_out_data;
    assign stream_out_empty         = r_out_empty;
    assign stream_out_valid         = r_out_valid;
    assign stream_out_startofpacket = r_out_sop;
    assign stream_out_endofpacket   = r_out_eop;

`ifdef ICMP_ECHO_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        logic [15:0] r;
        if (v == 16'hFFFF) begin
            r = v;
        end else begin
            r = v + 16'h0001;
        end
        return r;
    endfunction

    logic        w_ev_echo;
    logic        w_ev_pass;
    logic        w_ev_drop;
    logic        w_ev_ovf;
    logic [15:0] r_stat_echo;
    logic [15:0] r_stat_pass;
    logic [15:0] r_stat_drop;
    logic [15:0] r_stat_ovf;

    assign w_ev_echo = w_done && r_modify;
    assign w_ev_pass = w_done && !r_modify;
    assign w_ev_drop = ((r_state == S_CHECK) && !w_is_echo && (PASS_OTHER == 0)) ||
                       ((r_state == S_RECV) && w_in_fire && stream_in_startofpacket);
    assign w_ev_ovf  = (r_state == S_RECV) && w_in_fire && !stream_in_startofpacket &&
                       (r_wr_ptr == PW'(DEPTH));

    // Saturating event counters with synchronous clear.
    always_ff @(posedge clk) begin
        if (reset || stat_clear) begin
            r_stat_echo <= 16'h0000;
            r_stat_pass <= 16'h0000;
            r_stat_drop <= 16'h0000;
            r_stat_ovf  <= 16'h0000;
        end else begin
            if (w_ev_echo) r_stat_echo <= sat_inc(r_stat_echo);
            if (w_ev_pass) r_stat_pass <= sat_inc(r_stat_pass);
            if (w_ev_drop) r_stat_drop <= sat_inc(r_stat_drop);
            if (w_ev_ovf)  r_stat_ovf  <= sat_inc(r_stat_ovf);
        end
    end

    assign stat_echo_cnt = r_stat_echo;
    assign stat_pass_cnt = r_stat_pass;
    assign stat_drop_cnt = r_stat_drop;
    assign stat_ovf_cnt  = r_stat_ovf;
`endif

endmodule

`default_nettype wire

// File: tb/tb_icmp_echo_responder.sv
`timescale 1ns/1ps

module tb_icmp_echo_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [31:0] in_data;
    logic [1:0]  in_empty;
    logic        in_valid;
    logic        in_sop;
    logic        in_eop;
    logic        out_ready;
    logic        sel;      // 0 = instance A (DEPTH 64, pass), 1 = instance B (DEPTH 16, drop)

    logic        a_in_valid, b_in_valid;
    logic        a_in_ready, b_in_ready;
    logic [31:0] a_out_data, b_out_data;
    logic [1:0]  a_out_empty, b_out_empty;
    logic        a_out_valid, b_out_valid;
    logic        a_out_sop, b_out_sop;
    logic        a_out_eop, b_out_eop;

    assign a_in_valid = in_valid & ~sel;
    assign b_in_valid = in_valid & sel;

    logic        w_in_ready;
    logic [31:0] o_data;
    logic [1:0]  o_empty;
    logic        o_valid, o_sop, o_eop;
    assign w_in_ready = sel ? b_in_ready  : a_in_ready;
    assign o_data     = sel ? b_out_data  : a_out_data;
    assign o_empty    = sel ? b_out_empty : a_out_empty;
    assign o_valid    = sel ? b_out_valid : a_out_valid;
    assign o_sop      = sel ? b_out_sop   : a_out_sop;
    assign o_eop      = sel ? b_out_eop   : a_out_eop;

`ifdef ICMP_ECHO_STATS_EN
    logic        stat_clear;
    logic [15:0] a_echo, a_pass, a_drop, a_ovf;
    logic [15:0] b_echo, b_pass, b_drop, b_ovf;
`endif

    icmp_echo_responder #(.DEPTH(64), .PASS_OTHER(1)) dut_a (
        .clk(clk), .reset(reset),
        .stream_in_data(in_data), .stream_in_empty(in_empty), .stream_in_valid(a_in_valid),
        .stream_in_startofpacket(in_sop), .stream_in_endofpacket(in_eop),
        .stream_in_ready(a_in_ready),
        .stream_out_data(a_out_data), .stream_out_empty(a_out_empty),
        .stream_out_valid(a_out_valid), .stream_out_startofpacket(a_out_sop),
        .stream_out_endofpacket(a_out_eop), .stream_out_ready(out_ready)
`ifdef ICMP_ECHO_STATS_EN
        , .stat_clear(stat_clear), .stat_echo_cnt(a_echo), .stat_pass_cnt(a_pass),
        .stat_drop_cnt(a_drop), .stat_ovf_cnt(a_ovf)
`endif
    );

    icmp_echo_responder #(.DEPTH(16), .PASS_OTHER(0)) dut_b (
        .clk(clk), .reset(reset),
        .stream_in_data(in_data), .stream_in_empty(in_empty), .stream_in_valid(b_in_valid),
        .stream_in_startofpacket(in_sop), .stream_in_endofpacket(in_eop),
        .stream_in_ready(b_in_ready),
        .stream_out_data(b_out_data), .stream_out_empty(b_out_empty),
        .stream_out_valid(b_out_valid), .stream_out_startofpacket(b_out_sop),
        .stream_out_endofpacket(b_out_eop), .stream_out_ready(out_ready)
`ifdef ICMP_ECHO_STATS_EN
        , .stat_clear(stat_clear), .stat_echo_cnt(b_echo), .stat_pass_cnt(b_pass),
        .stat_drop_cnt(b_drop), .stat_ovf_cnt(b_ovf)
`endif
    );

    int checks   = 0;
    int failures = 0;

    logic [31:0] tx [64];
    logic [31:0] ex [64];
    logic [31:0] rx_d [64];
    logic        rx_sop [64];
    logic        rx_eop [64];
    logic [1:0]  rx_emp [64];
    int          rx_n;
    logic        rx_done;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Echo request: c = checksum in the packet, cp = hand-computed patched checksum.
    task automatic build_echo(input int n, input logic [15:0] c, input logic [15:0] cp);
        tx[0] = 32'h5400_0045;
        tx[1] = 32'h0040_3412;
        tx[2] = 32'h0000_0140;
        tx[3] = 32'h0A01_A8C0;
        tx[4] = 32'h1401_A8C0;
        tx[5] = {c[7:0], c[15:8], 8'h00, 8'h08};
        for (int i = 6; i < n; i++) tx[i] = 32'hC0DE_0000 + 32'(i);
        for (int i = 0; i < n; i++) ex[i] = tx[i];
        ex[3] = tx[4];
        ex[4] = tx[3];
        ex[5] = {cp[7:0], cp[15:8], 8'h00, 8'h00};
    endtask

    // UDP packet: forwarded byte-identical when passed.
    task automatic build_udp(input int n);
        tx[0] = 32'h2800_0045;
        tx[1] = 32'h0000_5678;
        tx[2] = 32'h0000_1140;
        tx[3] = 32'h0A01_A8C0;
        tx[4] = 32'h1401_A8C0;
        tx[5] = 32'h2C01_0835;
        for (int i = 6; i < n; i++) tx[i] = 32'hBEEF_0000 + 32'(i);
        for (int i = 0; i < n; i++) ex[i] = tx[i];
    endtask

    // Called at posedge+1; returns at posedge+1 after the beat transfers.
    task automatic send_beat(input logic [31:0] d, input logic s, input logic e, input logic [1:0] em);
        int g;
        in_data  = d;
        in_sop   = s;
        in_eop   = e;
        in_empty = em;
        in_valid = 1'b1;
        @(negedge clk);
        g = 0;
        while (!w_in_ready && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (g >= 200) check("in_ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic send_pkt(input int n, input logic [1:0] emp);
        for (int i = 0; i < n; i++)
            send_beat(tx[i], (i == 0), (i == n - 1), (i == n - 1) ? emp : 2'b00);
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
    endtask

    // mode 0: sink always ready; mode 1: ready toggles 1-0-1-0.
    task automatic recv(input int budget, input int mode);
        logic        stalled;
        logic [31:0] st_data;
        logic        st_eop;
        rx_n    = 0;
        rx_done = 1'b0;
        stalled = 1'b0;
        st_data = 32'h0;
        st_eop  = 1'b0;
        for (int cyc = 0; cyc < budget; cyc++) begin
            out_ready = (mode == 0) ? 1'b1 : ((cyc % 2) == 0);
            @(negedge clk);
            if (stalled) begin
                check("stall_valid", {31'h0, o_valid}, 32'd1);
                check("stall_data", o_data, st_data);
                check("stall_eop", {31'h0, o_eop}, {31'h0, st_eop});
                stalled = 1'b0;
            end
            if (o_valid && out_ready) begin
                if (rx_n < 64) begin
                    rx_d[rx_n]   = o_data;
                    rx_sop[rx_n] = o_sop;
                    rx_eop[rx_n] = o_eop;
                    rx_emp[rx_n] = o_empty;
                    rx_n++;
                end
                if (o_eop) rx_done = 1'b1;
            end else if (o_valid) begin
                stalled = 1'b1;
                st_data = o_data;
                st_eop  = o_eop;
            end
            @(posedge clk);
            #1;
            if (rx_done) break;
        end
        out_ready = 1'b1;
        if (rx_done) begin
            @(negedge clk);
            check("post_eop_valid", {31'h0, o_valid}, 32'd0);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic compare_rx(input int n, input logic [1:0] emp, input string nm);
        check({nm, "_done"}, {31'h0, rx_done}, 32'd1);
        check({nm, "_count"}, rx_n, n);
        for (int i = 0; i < n && i < rx_n; i++) begin
            check($sformatf("%s_data%0d", nm, i), rx_d[i], ex[i]);
            check($sformatf("%s_sop%0d", nm, i), {31'h0, rx_sop[i]}, (i == 0) ? 32'd1 : 32'd0);
            check($sformatf("%s_eop%0d", nm, i), {31'h0, rx_eop[i]}, (i == n - 1) ? 32'd1 : 32'd0);
            check($sformatf("%s_emp%0d", nm, i), {30'h0, rx_emp[i]}, (i == n - 1) ? {30'h0, emp} : 32'd0);
        end
    endtask

    initial begin
        int found;
        reset     = 1'b1;
        in_data   = 32'h0;
        in_empty  = 2'b00;
        in_valid  = 1'b0;
        in_sop    = 1'b0;
        in_eop    = 1'b0;
        out_ready = 1'b1;
        sel       = 1'b0;
`ifdef ICMP_ECHO_STATS_EN
        stat_clear = 1'b0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", {31'h0, a_in_ready}, 32'd0);
        check("rst_out_valid", {31'h0, a_out_valid}, 32'd0);
        check("rst_out_sop", {31'h0, a_out_sop}, 32'd0);
        check("rst_out_eop", {31'h0, a_out_eop}, 32'd0);
        check("rst_out_data", a_out_data, 32'h0);
        check("rst_out_empty", {30'h0, a_out_empty}, 32'd0);
        check("rst_b_out_valid", {31'h0, b_out_valid}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("idle_in_ready", {31'h0, a_in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // 21-word echo, checksum 0xF7FF -> 0xFFFF, sink always ready.
        build_echo(21, 16'hF7FF, 16'hFFFF);
        send_pkt(21, 2'b00);
        recv(200, 0);
        compare_rx(21, 2'b00, "echo1");

        // Same packet, checksum 0xF800 -> 0x0001 (end-around carry), sink toggling.
        build_echo(21, 16'hF800, 16'h0001);
        send_pkt(21, 2'b00);
        recv(300, 1);
        compare_rx(21, 2'b00, "echo2");

        // UDP, 10 words, empty 2, forwarded unchanged.
        build_udp(10);
        send_pkt(10, 2'b10);
        recv(200, 0);
        compare_rx(10, 2'b10, "udp_pass");

        // Same UDP into the dropping instance: nothing comes out.
        sel = 1'b1;
        send_pkt(10, 2'b10);
        recv(40, 0);
        check("udp_drop_count", rx_n, 32'd0);
`ifdef ICMP_ECHO_STATS_EN
        check("b_drop_cnt", {16'h0, b_drop}, 32'd1);
`endif

        // DEPTH 16: 20-word packet overflows, following 8-word echo is replied.
        build_echo(20, 16'h1111, 16'h1911);
        send_pkt(20, 2'b00);
        recv(40, 0);
        check("ovf_count", rx_n, 32'd0);
`ifdef ICMP_ECHO_STATS_EN
        check("b_ovf_cnt", {16'h0, b_ovf}, 32'd1);
`endif
        build_echo(8, 16'h1234, 16'h1A34);
        send_pkt(8, 2'b00);
        recv(200, 0);
        compare_rx(8, 2'b00, "b_echo");
        sel = 1'b0;

        // SOP restart at beat 4, then a full echo: only the echo comes out.
        send_beat(32'h3000_0045, 1'b1, 1'b0, 2'b00);
        send_beat(32'h0000_0001, 1'b0, 1'b0, 2'b00);
        send_beat(32'h0000_0140, 1'b0, 1'b0, 2'b00);
        send_beat(32'h0000_0003, 1'b0, 1'b0, 2'b00);
        build_echo(21, 16'h0000, 16'h0800);
        send_pkt(21, 2'b00);
        recv(200, 0);
        compare_rx(21, 2'b00, "restart");
`ifdef ICMP_ECHO_STATS_EN
        check("a_drop_cnt", {16'h0, a_drop}, 32'd1);
        check("a_echo_cnt", {16'h0, a_echo}, 32'd3);
        check("a_pass_cnt", {16'h0, a_pass}, 32'd1);
`endif

        // Reset while word 7 is presented, then a normal echo.
        build_echo(21, 16'hF7FF, 16'hFFFF);
        send_pkt(21, 2'b00);
        out_ready = 1'b1;
        found = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (o_valid && (o_data === ex[7])) begin
                found = 1;
                break;
            end
            @(posedge clk);
            #1;
        end
        check("found_word7", found, 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_send_valid", {31'h0, a_out_valid}, 32'd0);
        check("rst_send_in_ready", {31'h0, a_in_ready}, 32'd0);
        @(posedge clk);
        #1;
        build_echo(8, 16'hFFF0, 16'h07F1);
        send_pkt(8, 2'b00);
        recv(200, 0);
        compare_rx(8, 2'b00, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
